// File: rtl/mmio_uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - transmit FSM state encoding (3 bits)
//   - default register addresses on the processor data bus
//   - status-word bit positions
//   - even-parity helper used when MMIO_UART_TX_PARITY_EN is defined
// -----------------------------------------------------------------------------
package mmio_uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [31:0] DEF_TXDATA_ADDR = 32'h1001_0024;
  localparam logic [31:0] DEF_STATUS_ADDR = 32'h1001_0028;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_FULL = 1;
  localparam int unsigned STAT_OVR  = 2;
  localparam int unsigned STAT_PAR  = 3;

  // Even parity bit: makes the total count of ones (data + parity) even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mmio_uart_tx_baud.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; tick is high for the
// single clock in which the counter holds its last value. A synchronous clear
// restarts the count so every FSM state starts a fresh bit period.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   clr   - synchronous clear (counter returns to 0 on the next edge)
//   tick  - one-clock pulse marking the end of a bit period
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, otherwise wrap at LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/mmio_uart_tx.sv
// -----------------------------------------------------------------------------
// mmio_uart_tx
// Memory-mapped UART transmitter on the processor data-memory bus.
// A store to TXDATA_ADDR fills a one-byte holding register; the FSM moves it
// into a shifter and sends it 8N1 (or 8E1 when MMIO_UART_TX_PARITY_EN is
// defined). A load from STATUS_ADDR returns {.., PAR, OVR, FULL, BUSY}.
// Optional feature macro: MMIO_UART_TX_PARITY_EN (even parity bit + status
// capability flag in bit 3).
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   Address    - processor data address
//   WriteData  - store data, bits [7:0] used
//   MemWrite   - store strobe
//   MemRead    - load strobe
//   ReadData   - status word on a status read, else 0 (combinational)
//   Hit        - Address matches one of the two registers (combinational)
//   TxSerial   - UART line, idle high
//   TxBusy     - shifter active
// -----------------------------------------------------------------------------
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter logic [31:0] TXDATA_ADDR = DEF_TXDATA_ADDR,
  parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  output logic        Hit,
  output logic        TxSerial,
  output logic        TxBusy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam logic PAR_CAP = 1'b1;
`else
  localparam logic PAR_CAP = 1'b0;
`endif

  tx_state_e   state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        tx_serial_q, tx_serial_d;
  logic        busy_q, busy_d;
`ifdef MMIO_UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic        wr_tx_s;
  logic        rd_stat_s;
  logic        load_s;
  logic        tick_s;
  logic        tick_clr_s;
  logic [31:0] status_s;
  logic        unused_wdata_s;

  assign wr_tx_s        = MemWrite & (Address == TXDATA_ADDR);
  assign rd_stat_s      = MemRead & (Address == STATUS_ADDR);
  assign load_s         = (state_q == ST_IDLE) & hold_full_q;
  assign tick_clr_s     = (state_d != state_q);
  assign Hit            = (Address == TXDATA_ADDR) | (Address == STATUS_ADDR);
  assign unused_wdata_s = ^WriteData[31:8];

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst_n(reset),
    .clr  (tick_clr_s),
    .tick (tick_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; every non-idle state lasts one bit period per tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) state_d = ST_START;
        else             state_d = ST_IDLE;
      end
      ST_START: begin
        if (tick_s) state_d = ST_DATA;
        else        state_d = ST_START;
      end
      ST_DATA: begin
        if (tick_s && (bit_idx_q == 3'd7)) begin
`ifdef MMIO_UART_TX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (tick_s) state_d = ST_STOP;
        else        state_d = ST_PARITY;
      end
      ST_STOP: begin
        if (tick_s) state_d = ST_IDLE;
        else        state_d = ST_STOP;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register, overrun flag and shifter next values.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overrun_d   = overrun_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
`ifdef MMIO_UART_TX_PARITY_EN
    par_d       = par_q;
`endif
    if (load_s) begin
      shift_d     = hold_q;
      bit_idx_d   = 3'd0;
      hold_full_d = 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
      par_d       = even_parity(hold_q);
`endif
    end else if ((state_q == ST_DATA) && tick_s) begin
      shift_d   = {1'b0, shift_q[7:1]};
      bit_idx_d = bit_idx_q + 3'd1;
    end else begin
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
    end
    // A write on the transfer edge sees hold as free, so it is accepted.
    if (wr_tx_s && (!hold_full_q || load_s)) begin
      hold_d      = WriteData[7:0];
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end
    // A new overrun wins over a clearing status read on the same edge.
    if (wr_tx_s && hold_full_q && !load_s) begin
      overrun_d = 1'b1;
    end else if (rd_stat_s) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Output decode from the next state so the registered line changes on the
  // same edge as the state.
  always_comb begin
    tx_serial_d = 1'b1;
    busy_d      = 1'b1;
    case (state_d)
      ST_IDLE:   begin tx_serial_d = 1'b1;       busy_d = 1'b0; end
      ST_START:  begin tx_serial_d = 1'b0;       busy_d = 1'b1; end
      ST_DATA:   begin tx_serial_d = shift_d[0]; busy_d = 1'b1; end
`ifdef MMIO_UART_TX_PARITY_EN
      ST_PARITY: begin tx_serial_d = par_q;      busy_d = 1'b1; end
`else
      ST_PARITY: begin tx_serial_d = 1'b1;       busy_d = 1'b1; end
`endif
      ST_STOP:   begin tx_serial_d = 1'b1;       busy_d = 1'b1; end
      default:   begin tx_serial_d = 1'b1;       busy_d = 1'b0; end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      shift_q     <= 8'h00;
      bit_idx_q   <= 3'd0;
      tx_serial_q <= 1'b1;
      busy_q      <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      tx_serial_q <= tx_serial_d;
      busy_q      <= busy_d;
`ifdef MMIO_UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

  // Status word and load-path read data.
  always_comb begin
    status_s            = 32'd0;
    status_s[STAT_BUSY] = busy_q;
    status_s[STAT_FULL] = hold_full_q;
    status_s[STAT_OVR]  = overrun_q;
    status_s[STAT_PAR]  = PAR_CAP;
    if (rd_stat_s) begin
      ReadData = status_s;
    end else begin
      ReadData = 32'd0;
    end
  end

  assign TxSerial = tx_serial_q;
  assign TxBusy   = busy_q;

endmodule
